// File: rtl/player_ship.sv
// Player ship: frame-ticked motion with accelerate/coast/wall clamp, a
// hit -> explode -> respawn/dead life cycle, and a registered pixel
// classifier that draws the ship shape for the video scan.
module player_ship #(
    parameter int SCREEN_WIDTH   = 640,
    parameter int SHIP_WIDTH     = 60,
    parameter int SHIP_HEIGHT    = 30,
    parameter int V_OFFSET       = 10,
    parameter int H_OFFSET       = 10,
    parameter int RECT_PERCENT   = 15,
    parameter int ACCEL          = 2,
    parameter int MAX_SPEED      = 20,
    parameter int LIVES          = 3,
    parameter int EXPLODE_FRAMES = 32,
    parameter int INVULN_FRAMES  = 64,
    parameter int BLINK_SHIFT    = 2,
    parameter int NONE           = 7,
    parameter int BACKGROUND     = 0,
    parameter int SPACESHIP      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              left,
    input  logic              right,
    input  logic              hit,
    input  logic [9:0]        hPos,
    input  logic [9:0]        vPos,
    output logic [9:0]        gunPosition,
    output logic [2:0]        color,
    output logic signed [7:0] speed,
    output logic [2:0]        lives,
    output logic              vulnerable,
    output logic              gameOver
);

    typedef enum logic [1:0] {ST_ALIVE, ST_EXPLODING, ST_RESPAWN, ST_DEAD} state_e;

    localparam logic signed [11:0] HALF_W  = 12'(SHIP_WIDTH / 2);
    localparam logic signed [11:0] XMIN_C  = 12'(H_OFFSET + SHIP_WIDTH / 2);
    localparam logic signed [11:0] XMAX_C  = 12'(SCREEN_WIDTH - H_OFFSET - SHIP_WIDTH / 2);
    localparam logic signed [11:0] ACC_C   = 12'(ACCEL);
    localparam logic signed [11:0] MAXS_C  = 12'(MAX_SPEED);
    localparam logic signed [11:0] RW_C    = 12'(SHIP_WIDTH * RECT_PERCENT / 100);
    localparam logic signed [11:0] VTOP_C  = 12'(V_OFFSET);
    localparam logic signed [11:0] VBOT_C  = 12'(V_OFFSET + SHIP_HEIGHT);
    localparam logic [9:0]         CENTER_C = 10'(SCREEN_WIDTH / 2);
    localparam logic [7:0]         CNT_EXP_C = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0]         CNT_INV_C = 8'(INVULN_FRAMES - 1);
    localparam logic [2:0]         COL_NONE  = 3'(NONE);
    localparam logic [2:0]         COL_BG    = 3'(BACKGROUND);
    localparam logic [2:0]         COL_SHIP  = 3'(SPACESHIP);
    localparam logic [2:0]         LIVES_C   = 3'(LIVES);

    state_e            state_q, state_d;
    logic [9:0]        gun_q, gun_d;
    logic signed [7:0] speed_q, speed_d;
    logic [2:0]        lives_q, lives_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        color_q, color_d;

    logic signed [11:0] sp_cur_s, sp_acc_s, sp_sat_s, pos_raw_s, pos_fin_s, sp_fin_s;
    logic signed [11:0] hs_s, vs_s, gs_s, dx_s, adx_s;
    logic               in_box_s, shape_s;

    // Candidate next speed/position for a movement frame (used only when the FSM allows motion)
    always_comb begin
        sp_cur_s = {{4{speed_q[7]}}, speed_q};
        if (right && !left) begin
            sp_acc_s = sp_cur_s + ACC_C;
        end else if (left && !right) begin
            sp_acc_s = sp_cur_s - ACC_C;
        end else if (sp_cur_s > ACC_C) begin
            sp_acc_s = sp_cur_s - ACC_C;
        end else if (sp_cur_s < -ACC_C) begin
            sp_acc_s = sp_cur_s + ACC_C;
        end else begin
            sp_acc_s = 12'sd0;  // within one step of zero: stop without crossing
        end
        if (sp_acc_s > MAXS_C) begin
            sp_sat_s = MAXS_C;
        end else if (sp_acc_s < -MAXS_C) begin
            sp_sat_s = -MAXS_C;
        end else begin
            sp_sat_s = sp_acc_s;
        end
        pos_raw_s = $signed({2'b00, gun_q}) + sp_sat_s;
        if (pos_raw_s < XMIN_C) begin
            pos_fin_s = XMIN_C;
            sp_fin_s  = 12'sd0;
        end else if (pos_raw_s > XMAX_C) begin
            pos_fin_s = XMAX_C;
            sp_fin_s  = 12'sd0;
        end else begin
            pos_fin_s = pos_raw_s;
            sp_fin_s  = sp_sat_s;
        end
    end

    // Life-cycle FSM next state plus position, speed, lives and frame counter
    always_comb begin
        state_d = state_q;
        gun_d   = gun_q;
        speed_d = speed_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ALIVE: begin
                if (hit) begin
                    // hit wins over a coincident frame tick: no movement this cycle
                    state_d = ST_EXPLODING;
                    speed_d = 8'sd0;
                    cnt_d   = CNT_EXP_C;
                    if (lives_q != 3'd0) begin
                        lives_d = lives_q - 3'd1;
                    end else begin
                        lives_d = lives_q;
                    end
                end else if (enable) begin
                    gun_d   = pos_fin_s[9:0];
                    speed_d = sp_fin_s[7:0];
                end else begin
                    state_d = ST_ALIVE;
                end
            end
            ST_EXPLODING: begin
                if (enable) begin
                    if (cnt_q == 8'd0) begin
                        if (lives_q == 3'd0) begin
                            state_d = ST_DEAD;
                        end else begin
                            state_d = ST_RESPAWN;
                            gun_d   = CENTER_C;
                            cnt_d   = CNT_INV_C;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    state_d = ST_EXPLODING;
                end
            end
            ST_RESPAWN: begin
                if (enable) begin
                    gun_d   = pos_fin_s[9:0];
                    speed_d = sp_fin_s[7:0];
                    if (cnt_q == 8'd0) begin
                        state_d = ST_ALIVE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    state_d = ST_RESPAWN;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    // Pixel classification for the current scan position
    always_comb begin
        hs_s     = $signed({2'b00, hPos});
        vs_s     = $signed({2'b00, vPos});
        gs_s     = $signed({2'b00, gun_q});
        dx_s     = hs_s - gs_s;
        adx_s    = (dx_s < 12'sd0) ? -dx_s : dx_s;
        in_box_s = (vs_s > VTOP_C) && (vs_s < VBOT_C) &&
                   (hs_s > gs_s - HALF_W) && (hs_s < gs_s + HALF_W);
        shape_s  = ((hs_s - (gs_s - HALF_W)) <= RW_C) ||
                   (((gs_s + HALF_W) - hs_s) <= RW_C) ||
                   (vs_s == VTOP_C + 12'sd1) ||
                   ((adx_s < (VBOT_C - vs_s)) && (dx_s != 12'sd0));
        color_d  = COL_NONE;
        if (!in_box_s) begin
            color_d = COL_NONE;
        end else begin
            case (state_q)
                ST_ALIVE:     color_d = shape_s ? COL_SHIP : COL_BG;
                ST_EXPLODING: color_d = (hPos[0] ^ vPos[0] ^ cnt_q[0]) ? COL_SHIP : COL_BG;
                ST_RESPAWN:   color_d = (!cnt_q[BLINK_SHIFT] && shape_s) ? COL_SHIP : COL_BG;
                ST_DEAD:      color_d = COL_NONE;
                default:      color_d = COL_NONE;
            endcase
        end
    end

    // State, motion and life registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ALIVE;
            gun_q   <= CENTER_C;
            speed_q <= 8'sd0;
            lives_q <= LIVES_C;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gun_q   <= gun_d;
            speed_q <= speed_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pixel colour register (one-cycle latency from hPos/vPos)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_q <= COL_NONE;
        end else begin
            color_q <= color_d;
        end
    end

    assign gunPosition = gun_q;
    assign speed       = speed_q;
    assign lives       = lives_q;
    assign color       = color_q;
    assign vulnerable  = (state_q == ST_ALIVE);
    assign gameOver    = (state_q == ST_DEAD);

endmodule

// File: tb/tb_player_ship.sv
// Scoreboard bench for player_ship: a behavioural ship model predicts every
// cycle's outputs, pushes them to a queue, and a monitor compares after each edge.
module tb_player_ship;

    localparam int S_ALIVE = 0, S_EXP = 1, S_RESP = 2, S_DEAD = 3;

    logic              clk = 1'b0;
    logic              reset, enable, left, right, hit;
    logic [9:0]        hPos, vPos;
    logic [9:0]        gunPosition;
    logic [2:0]        color;
    logic signed [7:0] speed;
    logic [2:0]        lives;
    logic              vulnerable, gameOver;

    player_ship dut (
        .clk(clk), .reset(reset), .enable(enable), .left(left), .right(right),
        .hit(hit), .hPos(hPos), .vPos(vPos), .gunPosition(gunPosition),
        .color(color), .speed(speed), .lives(lives), .vulnerable(vulnerable),
        .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gun; int spd; int lives; int vul; int go; int col;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    int m_state, m_gun, m_spd, m_lives, m_cnt;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_ALIVE; m_gun = 320; m_spd = 0; m_lives = 3; m_cnt = 0;
    endtask

    task automatic model_move(input bit l, input bit r);
        int s, p;
        s = m_spd;
        if (r && !l)       s = s + 2;
        else if (l && !r)  s = s - 2;
        else if (s > 0)    s = (s >= 2) ? s - 2 : 0;
        else if (s < 0)    s = (s <= -2) ? s + 2 : 0;
        if (s > 20)  s = 20;
        if (s < -20) s = -20;
        p = m_gun + s;
        if (p < 40)       begin p = 40;  s = 0; end
        else if (p > 600) begin p = 600; s = 0; end
        m_gun = p; m_spd = s;
    endtask

    task automatic model_step(input bit en, input bit l, input bit r, input bit h);
        if (m_state == S_ALIVE && h) begin
            m_state = S_EXP; m_lives = m_lives - 1; m_spd = 0; m_cnt = 31;
        end else if (en) begin
            case (m_state)
                S_ALIVE: model_move(l, r);
                S_EXP: begin
                    if (m_cnt == 0) begin
                        if (m_lives == 0) m_state = S_DEAD;
                        else begin m_state = S_RESP; m_gun = 320; m_cnt = 63; end
                    end else m_cnt = m_cnt - 1;
                end
                S_RESP: begin
                    model_move(l, r);
                    if (m_cnt == 0) m_state = S_ALIVE;
                    else m_cnt = m_cnt - 1;
                end
                default: ;
            endcase
        end
    endtask

    function automatic int model_color(input int hp, input int vp);
        bit box, shape;
        int dx;
        dx    = (hp > m_gun) ? hp - m_gun : m_gun - hp;
        box   = (vp > 10) && (vp < 40) && (hp > m_gun - 30) && (hp < m_gun + 30);
        shape = (hp - (m_gun - 30) <= 9) || ((m_gun + 30) - hp <= 9) ||
                (vp == 11) || ((dx < 40 - vp) && (hp != m_gun));
        if (!box || m_state == S_DEAD) return 7;
        if (m_state == S_ALIVE) return shape ? 1 : 0;
        if (m_state == S_EXP)   return (((hp ^ vp ^ m_cnt) & 1) == 1) ? 1 : 0;
        return (((m_cnt >> 2) & 1) == 0 && shape) ? 1 : 0;
    endfunction

    // Drive one cycle of stimulus and queue the model's prediction for after the edge
    task automatic drive(input bit en, input bit l, input bit r, input bit h,
                         input int hp, input int vp);
        exp_t e;
        @(negedge clk);
        enable = en; left = l; right = r; hit = h;
        hPos = 10'(hp); vPos = 10'(vp);
        e.col = model_color(hp, vp);
        model_step(en, l, r, h);
        e.gun = m_gun; e.spd = m_spd; e.lives = m_lives;
        e.vul = (m_state == S_ALIVE) ? 1 : 0;
        e.go  = (m_state == S_DEAD) ? 1 : 0;
        sb_q.push_back(e);
    endtask

    // Frame tick with a random pixel near the ship
    task automatic frame(input bit l, input bit r, input bit h);
        drive(1'b1, l, r, h, m_gun - 34 + int'($urandom_range(0, 68)),
              int'($urandom_range(8, 42)));
    endtask

    task automatic idle(input bit h);
        drive(1'b0, 1'b0, 1'b0, h, m_gun - 34 + int'($urandom_range(0, 68)),
              int'($urandom_range(8, 42)));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_gun"}, int'(gunPosition), 320);
        check_eq({tag, "_speed"}, int'(speed), 0);
        check_eq({tag, "_lives"}, int'(lives), 3);
        check_eq({tag, "_vuln"}, int'(vulnerable), 1);
        check_eq({tag, "_gameover"}, int'(gameOver), 0);
        check_eq({tag, "_color"}, int'(color), 7);
    endtask

    // Monitor: compare DUT outputs just after each edge against queued predictions
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check_eq("gun", int'(gunPosition), mon_e.gun);
            check_eq("speed", int'(speed), mon_e.spd);
            check_eq("lives", int'(lives), mon_e.lives);
            check_eq("vulnerable", int'(vulnerable), mon_e.vul);
            check_eq("gameOver", int'(gameOver), mon_e.go);
            check_eq("color", int'(color), mon_e.col);
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; left = 1'b0; right = 1'b0; hit = 1'b0;
        hPos = 10'd0; vPos = 10'd0;
        model_reset();

        // inputs toggling while reset is held must have no effect
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            enable = 1'b1; right = 1'(i % 2); left = 1'(1 - i % 2); hit = 1'b1;
            hPos = 10'd300; vPos = 10'd20;
        end
        @(negedge clk);
        check_reset_values("held_reset");
        enable = 1'b0; left = 1'b0; right = 1'b0; hit = 1'b0;
        reset = 1'b0;

        // pixel scan around the centred ship
        drive(1'b0, 1'b0, 1'b0, 1'b0, 292, 20);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 320, 20);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 305, 11);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 400, 20);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 290, 20);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 320, 10);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 320, 40);

        // acceleration to the right wall, then reverse
        repeat (12) frame(1'b0, 1'b1, 1'b0);
        repeat (7)  frame(1'b0, 1'b1, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        repeat (3)  frame(1'b0, 1'b0, 1'b0);
        repeat (5)  frame(1'b1, 1'b0, 1'b0);
        repeat (4)  frame(1'b1, 1'b1, 1'b0);
        repeat (40) frame(1'b1, 1'b0, 1'b0);
        repeat (3)  idle(1'b0);
        repeat (6)  frame(1'b0, 1'b1, 1'b0);

        // hit coincident with a frame tick, then explosion with ignored hits
        frame(1'b0, 1'b1, 1'b1);
        repeat (4) idle(1'b1);
        repeat (32) frame(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b0);
        frame(1'b0, 1'b1, 1'b1);
        repeat (63) frame(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b0);
        repeat (3) frame(1'b0, 1'b1, 1'b0);

        // two more lives lost: second ends in game over, then controls are dead
        for (int k = 0; k < 2; k++) begin
            idle(1'b1);
            repeat (32) frame(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b0);
            repeat (64) frame(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'($urandom_range(0, 1)));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 320, 20);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 305, 11);

        // fresh game, then asynchronous reset in the middle of an explosion
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; left = 1'b0; right = 1'b0; hit = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) frame(1'b0, 1'b1, 1'b0);
        idle(1'b1);
        repeat (5) frame(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        enable = 1'b0; left = 1'b0; right = 1'b0; hit = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (4) frame(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 332, 20);

        @(negedge clk);
        enable = 1'b0; left = 1'b0; right = 1'b0; hit = 1'b0;
        @(negedge clk);
        check_eq("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
